// File: rtl/rv32i_wb_mem_slave.sv
// Wishbone (pipelined) word-addressed memory slave for an RV32I core.
// One request in flight: accept in IDLE, WAIT_STATES idle cycles, then a
// single-cycle ack or err in RESP. Writes commit in RESP with byte lanes.
module rv32i_wb_mem_slave #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned           WAIT_STATES = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    wb_stall_o
);

   localparam int unsigned         NB   = DATA_WIDTH / 8;
   localparam int unsigned         IDXW = $clog2(DEPTH_WORDS);
   // Size of the decoded window in bytes, one bit wider than the address so
   // a window reaching the top of the address space still compares correctly.
   localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   state_e                  state_q;
   logic [3:0]              cnt_q;
   logic [ADDR_WIDTH-1:0]   adr_q;
   logic                    we_q;
   logic [NB-1:0]           sel_q;
   logic [DATA_WIDTH-1:0]   wdat_q;
   logic                    ack_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   rdat_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

   // Request seen by the response logic: live bus in IDLE (needed when
   // WAIT_STATES = 0 and RESP follows the accept edge), captured copy after.
   logic [ADDR_WIDTH-1:0]   req_adr;
   logic                    req_we;
   logic [NB-1:0]           req_sel;
   logic                    req_err;
   logic [IDXW-1:0]         req_idx;
   logic                    cap_err;
   logic [IDXW-1:0]         cap_idx;
   logic                    accept;
   logic                    commit;

   // Out of window, misaligned, or a read with no lanes selected.
   function automatic logic bad_request(input logic [ADDR_WIDTH-1:0] adr,
                                        input logic                  we,
                                        input logic [NB-1:0]         sel);
      logic [ADDR_WIDTH:0] off;
      off = {1'b0, adr} - {1'b0, BASE_ADDR};
      bad_request = ({1'b0, adr} < {1'b0, BASE_ADDR}) || (off >= SPAN) ||
                    (adr[1:0] != 2'b00) || (!we && (sel == '0));
   endfunction

   // Word index inside the window: (adr - BASE_ADDR) >> 2, truncated.
   function automatic logic [IDXW-1:0] word_index(input logic [ADDR_WIDTH-1:0] adr);
      logic [ADDR_WIDTH-1:0] off;
      off = adr - BASE_ADDR;
      word_index = IDXW'(off >> 2);
   endfunction

   // Select which request the response logic decodes.
   always_comb begin
      // NOTE: every output of an always_comb gets a default first so that
      // no path leaves it unassigned and a latch can never be inferred.
      req_adr = adr_q;
      req_we  = we_q;
      req_sel = sel_q;
      if (state_q == ST_IDLE) begin
         req_adr = wb_adr_i;
         req_we  = wb_we_i;
         req_sel = wb_sel_i;
      end
   end

   assign req_err    = bad_request(req_adr, req_we, req_sel);
   assign req_idx    = word_index(req_adr);
   assign cap_err    = bad_request(adr_q, we_q, sel_q);
   assign cap_idx    = word_index(adr_q);
   assign wb_stall_o = (state_q != ST_IDLE);
   assign accept     = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
   assign commit     = (state_q == ST_RESP) && we_q && !cap_err && !rst_i;

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_dat_o = rdat_q;

   // Transfer FSM with registered ack/err/data, loaded on entry to RESP.
   always_ff @(posedge clk_i) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wdat_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         rdat_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  adr_q  <= wb_adr_i;
                  we_q   <= wb_we_i;
                  sel_q  <= wb_sel_i;
                  wdat_q <= wb_dat_i;
                  if (WAIT_STATES == 0) begin
                     state_q <= ST_RESP;
                     ack_q   <= !req_err;
                     err_q   <= req_err;
                     rdat_q  <= (!req_err && !req_we) ? mem_q[req_idx] : '0;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (!wb_cyc_i) begin
                  state_q <= ST_IDLE;
               end else if (cnt_q == '0) begin
                  state_q <= ST_RESP;
                  ack_q   <= !req_err;
                  err_q   <= req_err;
                  rdat_q  <= (!req_err && !req_we) ? mem_q[req_idx] : '0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Byte-lane write commit during the RESP cycle of a good write.
   always_ff @(posedge clk_i) begin
      // NOTE: the memory array has no reset; its contents survive rst_i and
      // it can map onto block RAM.
      if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (sel_q[b]) begin
               mem_q[cap_idx][8*b +: 8] <= wdat_q[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: doc/rv32i_wb_mem_slave.md
RV32I_WB_MEM_SLAVE -- requirements
Module: rv32i_wb_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: Wishbone byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, fixed at 32 for RV32I.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024: number of backing words, a power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000: first byte address decoded, aligned to DEPTH_WORDS*4.
REQ-005 SHALL have parameter WAIT_STATES, default 1, legal range 0..15: idle cycles inserted between accept and response.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port wb_cyc_i, input, 1 bit: bus cycle active.
REQ-009 SHALL have port wb_stb_i, input, 1 bit: request strobe.
REQ-010 SHALL have port wb_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port wb_sel_i, input, DATA_WIDTH/8 bits: byte lane enables.
REQ-012 SHALL have port wb_adr_i, input, ADDR_WIDTH bits: byte address.
REQ-013 SHALL have port wb_dat_i, input, DATA_WIDTH bits: write data.
REQ-014 SHALL have port wb_dat_o, output, DATA_WIDTH bits: read data.
REQ-015 SHALL have port wb_ack_o, output, 1 bit: successful termination.
REQ-016 SHALL have port wb_err_o, output, 1 bit: error termination.
REQ-017 SHALL have port wb_stall_o, output, 1 bit: pipelined-mode stall.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-019 SHALL set wb_stall_o = 1 in WAIT and RESP, and 0 in IDLE (driven combinationally from state).
REQ-020 SHALL accept a request in IDLE when wb_cyc_i & wb_stb_i & !wb_stall_o, and register adr, we, sel and dat_i on that edge.
REQ-021 SHALL go IDLE -> WAIT on accept when WAIT_STATES > 0 and load the wait counter with WAIT_STATES-1; when WAIT_STATES = 0, SHALL go IDLE -> RESP directly.
REQ-022 SHALL decrement the counter in WAIT and go WAIT -> RESP when the counter is 0.
REQ-023 SHALL go RESP -> IDLE unconditionally after one cycle.
REQ-024 SHALL produce its response exactly 1+WAIT_STATES cycles after the accept edge.
REQ-025 SHALL assert exactly one of wb_ack_o or wb_err_o, for exactly one cycle, in RESP and only then.
REQ-026 SHALL flag an error on any of: address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4); adr[1:0] != 0; wb_sel_i = 0 on a read.
- On error: assert wb_err_o, perform no memory write, drive wb_dat_o = 0.
REQ-027 SHALL commit a write in the RESP cycle only, updating only the byte lanes whose sel bit is set; a write with sel = 0 acks with no change.
REQ-028 SHALL index memory by word: (adr - BASE_ADDR) >> 2, using log2(DEPTH_WORDS) bits.
REQ-029 SHALL drive wb_dat_o with the addressed word during a read ack, and 0 in all other cycles, including write acks.
REQ-030 SHALL abort when wb_cyc_i falls during WAIT: return to IDLE next edge, no ack, no err, no write.
- Abort is not checked in the RESP cycle; RESP completes normally.
REQ-031 SHALL ignore wb_stb_i while in WAIT or RESP, with no queuing.
- Back-to-back requests are accepted every 2+WAIT_STATES cycles at most.
REQ-032 SHALL ignore wb_stb_i while wb_cyc_i = 0.

Reset
REQ-033 SHALL, while rst_i = 1 at a clock edge, enter IDLE and clear the counter and captured request; the outputs take these values:
- wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, wb_stall_o = 0.
REQ-034 SHALL abandon any in-flight transfer when reset is asserted mid-operation, with no response and no write.
REQ-035 SHALL NOT reset memory contents.

Verification
REQ-036 SHALL cover a write then read with WAIT_STATES = 1, BASE = 0:
- Write 0xDEADBEEF to adr 0x10, sel = 4'hF -> ack 2 cycles after accept.
- Read of adr 0x10 -> ack with dat_o = 0xDEADBEEF.
REQ-037 SHALL cover a partial write: write 0x0000AA00 to adr 0x10 with sel = 4'b0010 -> subsequent read returns 0xDEADAAEF.
REQ-038 SHALL cover error cases, each returning err for one cycle with dat_o = 0 and memory unchanged:
- adr 0x1000 with DEPTH_WORDS = 1024 (out of range).
- adr 0x12 (misaligned).
REQ-039 SHALL cover abort: accept a write to 0x20, drop wb_cyc_i in WAIT -> no ack or err, and a later read of 0x20 returns the prior value.
REQ-040 SHALL cover stall/no-double-accept: hold stb = 1 continuously over two reads -> exactly two acks, spaced 2+WAIT_STATES cycles apart, with wb_stall_o = 1 between them.
REQ-041 SHALL cover WAIT_STATES = 0 and mid-transfer reset:
- WAIT_STATES = 0 -> ack on the cycle after accept.
- rst_i asserted in WAIT -> no ack, and IDLE with stall = 0 the next cycle.
